bram_log_streamer: RTL and testbench
====================================

BRAM_LOG_STREAMER -- requirements
Module: bram_log_streamer

Interface
REQ-001 SHALL have parameter LOG_DATA_BITW, default 32, meaning payload bits per log entry (multiple of 32).
REQ-002 SHALL have parameter NUM_LOG_ENTRIES, default 16384, meaning log depth in entries (>=1024, power of two).
REQ-003 SHALL derive ENTRY_BITW = 32 + LOG_DATA_BITW, ENTRY_BYTEW = ENTRY_BITW/8, CNT_BITW = log2(NUM_LOG_ENTRIES), ADDR_BITW = CNT_BITW + log2(ENTRY_BYTEW).
REQ-004 Clk_CI  in  1  sole clock; all logic rising-edge.
REQ-005 Rst_RBI  in  1  reset, asynchronous, active-low.
REQ-006 Start_SI  in  1  start a read-out pass; sampled only in IDLE.
REQ-007 Abort_SI  in  1  cancel a pass in progress.
REQ-008 NumEntries_DI  in  CNT_BITW+1  entries to read, from index 0; sampled with Start_SI.
REQ-009 BramEn_SO  out  1  BRAM read enable (read-only port, write enable tied low).
REQ-010 BramAddr_SO  out  ADDR_BITW  BRAM byte address = entry index << log2(ENTRY_BYTEW).
REQ-011 BramRdData_DI  in  ENTRY_BITW  BRAM read data, valid exactly one cycle after BramEn_SO.
REQ-012 Valid_SO  out  1  output entry valid.
REQ-013 Ready_SI  in  1  downstream accepts entry.
REQ-014 Timestamp_DO  out  32  entry bits [31:0].
REQ-015 LogData_DO  out  LOG_DATA_BITW  entry bits [ENTRY_BITW-1:32].
REQ-016 EntryIdx_DO  out  CNT_BITW  index of entry on output.
REQ-017 Busy_SO  out  1  high in any state except IDLE.
REQ-018 Done_SO  out  1  one-cycle pulse at end of a completed (non-aborted) pass.

Function
REQ-019 SHALL implement FSM states IDLE, STREAM, DONE.
REQ-020 IDLE -> STREAM when Start_SI=1; latch N = min(NumEntries_DI, NUM_LOG_ENTRIES); reset read and output counters to 0.
REQ-021 STREAM -> DONE when N entries have been handshaken (Valid_SO & Ready_SI); DONE lasts one cycle with Done_SO=1, then -> IDLE.
REQ-022 Start_SI with N=0 SHALL go STREAM -> DONE without any BramEn_SO pulse.
REQ-023 Start_SI outside IDLE SHALL be ignored.
REQ-024 Abort_SI in STREAM or DONE SHALL go to IDLE next cycle, flush buffer, drop in-flight read data, and suppress Done_SO; Abort_SI has priority over all other transitions.
REQ-025 SHALL buffer read data in a 2-entry FIFO; a read is issued only if (FIFO occupancy + reads in flight) < 2 and issued count < N.
REQ-026 Valid_SO/data SHALL come from the FIFO head (registered); Valid_SO once high SHALL stay high with stable data until Ready_SI=1.
REQ-027 Latency: Start_SI in cycle 0 -> BramEn_SO for index 0 in cycle 1 -> Valid_SO in cycle 3.
REQ-028 Throughput: with Ready_SI held high, one entry per cycle sustained after first entry.
REQ-029 Entries SHALL be emitted in ascending index order, none skipped or duplicated, EntryIdx_DO matching source index.
REQ-030 BramAddr_SO SHALL be 0 whenever BramEn_SO=0.
REQ-031 Counters SHALL be CNT_BITW+1 wide so N = NUM_LOG_ENTRIES completes without wrap.

Reset
REQ-032 On Rst_RBI=0: state IDLE, FIFO empty, counters 0; Valid_SO, BramEn_SO, Busy_SO, Done_SO = 0; BramAddr_SO, EntryIdx_DO, Timestamp_DO, LogData_DO = 0.
REQ-033 Reset asserted mid-pass SHALL abandon the pass without Done_SO; BRAM contents are not touched.

Verification
REQ-034 N=4, Ready_SI=1, BRAM word i = {i+100, i} -> Valid in cycles 3..6, Timestamp_DO=0..3, LogData_DO=100..103, Done_SO pulse cycle 7.
REQ-035 N=8, Ready_SI toggling 1/0 each cycle -> exactly 8 handshakes, in order, data stable while stalled, never more than 2 reads outstanding+buffered.
REQ-036 Start with NumEntries_DI=0 -> no BramEn_SO, Done_SO in cycle 2, Busy_SO high cycles 1..2.
REQ-037 N=NUM_LOG_ENTRIES (16384) -> last EntryIdx_DO=16383, BramAddr_SO max = 16383<<3, then Done_SO, counter no wrap.
REQ-038 Abort_SI after 3 handshakes of N=10 -> IDLE next cycle, Valid_SO=0, no Done_SO; new Start with N=2 returns indices 0,1.
REQ-039 Rst_RBI pulsed low asynchronously mid-pass -> all outputs 0 immediately, IDLE, no Done_SO.

Source files
------------

// File: rtl/bram_log_streamer.sv
// Streams log entries 0..N-1 out of a read-only BRAM port into a valid/ready stream.
// A 2-entry FIFO absorbs the one-cycle BRAM read latency so full throughput survives backpressure.
module bram_log_streamer #(
    parameter int unsigned LOG_DATA_BITW   = 32,
    parameter int unsigned NUM_LOG_ENTRIES = 16384,
    localparam int unsigned ENTRY_BITW     = 32 + LOG_DATA_BITW,
    localparam int unsigned ENTRY_BYTEW    = ENTRY_BITW / 8,
    localparam int unsigned CNT_BITW       = $clog2(NUM_LOG_ENTRIES),
    localparam int unsigned ADDR_BITW      = CNT_BITW + $clog2(ENTRY_BYTEW)
) (
    input  logic                     Clk_CI,
    input  logic                     Rst_RBI,
    input  logic                     Start_SI,
    input  logic                     Abort_SI,
    input  logic [CNT_BITW:0]        NumEntries_DI,
    output logic                     BramEn_SO,
    output logic [ADDR_BITW-1:0]     BramAddr_SO,
    input  logic [ENTRY_BITW-1:0]    BramRdData_DI,
    output logic                     Valid_SO,
    input  logic                     Ready_SI,
    output logic [31:0]              Timestamp_DO,
    output logic [LOG_DATA_BITW-1:0] LogData_DO,
    output logic [CNT_BITW-1:0]      EntryIdx_DO,
    output logic                     Busy_SO,
    output logic                     Done_SO
);

    localparam int unsigned BYTE_SHIFT = $clog2(ENTRY_BYTEW);
    localparam logic [CNT_BITW:0] MAX_N = (CNT_BITW+1)'(NUM_LOG_ENTRIES);
    localparam logic [CNT_BITW:0] CNT_ONE = (CNT_BITW+1)'(1);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e                state_q, state_d;
    logic [CNT_BITW:0]     n_q, rd_cnt_q, out_cnt_q;
    logic                  inflight_q;
    logic [1:0]            fifo_cnt_q;
    logic [ENTRY_BITW-1:0] head_q, tail_q;

    logic       valid, hs, issue, abort_act;
    logic [2:0] used;

    always_comb begin
        valid     = (fifo_cnt_q != 2'd0);
        hs        = valid & Ready_SI;
        abort_act = Abort_SI & (state_q != StIdle);
        // Count the slot freed by this cycle's handshake so back-to-back reads keep going.
        used      = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, hs};
        issue     = (state_q == StStream) & ~Abort_SI & (rd_cnt_q < n_q) & (used < 3'd2);

        state_d = state_q;
        case (state_q)
            StIdle:   if (Start_SI) state_d = StStream;
            StStream: if ((out_cnt_q + (CNT_BITW+1)'(hs)) == n_q) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (abort_act) state_d = StIdle;
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q    <= StIdle;
            n_q        <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            fifo_cnt_q <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (state_q == StIdle && Start_SI) begin
                n_q       <= (NumEntries_DI > MAX_N) ? MAX_N : NumEntries_DI;
                rd_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                if (issue) rd_cnt_q  <= rd_cnt_q + CNT_ONE;
                if (hs)    out_cnt_q <= out_cnt_q + CNT_ONE;
            end
            // Abort flushes the buffer and discards any read returning this cycle.
            if (abort_act) begin
                fifo_cnt_q <= 2'd0;
            end else begin
                case ({inflight_q, hs})
                    2'b10: begin
                        if (fifo_cnt_q == 2'd0) head_q <= BramRdData_DI;
                        else                    tail_q <= BramRdData_DI;
                        fifo_cnt_q <= fifo_cnt_q + 2'd1;
                    end
                    2'b01: begin
                        head_q     <= tail_q;
                        fifo_cnt_q <= fifo_cnt_q - 2'd1;
                    end
                    2'b11: begin
                        if (fifo_cnt_q == 2'd1) begin
                            head_q <= BramRdData_DI;
                        end else begin
                            head_q <= tail_q;
                            tail_q <= BramRdData_DI;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        BramEn_SO    = issue;
        BramAddr_SO  = issue ? {rd_cnt_q[CNT_BITW-1:0], {BYTE_SHIFT{1'b0}}} : '0;
        Valid_SO     = valid;
        Timestamp_DO = head_q[31:0];
        LogData_DO   = head_q[ENTRY_BITW-1:32];
        EntryIdx_DO  = valid ? out_cnt_q[CNT_BITW-1:0] : '0;
        Busy_SO      = (state_q != StIdle);
        Done_SO      = (state_q == StDone) & ~Abort_SI;
    end

endmodule

// File: tb/tb_bram_log_streamer.sv
// Directed bench for bram_log_streamer: latency, backpressure, empty pass, full depth,
// abort and asynchronous reset, against a behavioural one-cycle-latency BRAM.
module tb_bram_log_streamer;

    localparam int LW = 32;
    localparam int NE = 16384;
    localparam int CW = 14;
    localparam int AW = 17;
    localparam int EW = 64;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b0;
    logic [CW:0]   num = '0;
    logic          en, valid, busy, done;
    logic [AW-1:0] addr;
    logic [EW-1:0] rdata;
    logic [31:0]   ts;
    logic [LW-1:0] ld;
    logic [CW-1:0] idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Word i holds {i+100, i}.
    always @(posedge clk) if (en) rdata <= {32'(addr >> 3) + 32'd100, 32'(addr >> 3)};

    bram_log_streamer #(.LOG_DATA_BITW(LW), .NUM_LOG_ENTRIES(NE)) dut (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Abort_SI(abort),
        .NumEntries_DI(num), .BramEn_SO(en), .BramAddr_SO(addr), .BramRdData_DI(rdata),
        .Valid_SO(valid), .Ready_SI(ready), .Timestamp_DO(ts), .LogData_DO(ld),
        .EntryIdx_DO(idx), .Busy_SO(busy), .Done_SO(done)
    );

    task automatic test_reset;
        #2;
        n_checks++;
        if ({valid, en, busy, done, addr, idx, ts, ld} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b en=%b busy=%b done=%b addr=%0h idx=%0d ts=%0h ld=%0h, want all 0",
                     valid, en, busy, done, addr, idx, ts, ld);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        start = 1'b1; num = 15'd4; ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (valid !== (c >= 3 && c <= 6)) begin
                n_fail++; $display("FAIL basic_valid c=%0d: got %b", c, valid);
            end
            if (c >= 3 && c <= 6) begin
                n_checks++;
                if (ts !== 32'(c-3) || ld !== 32'(c-3+100) || idx !== CW'(c-3)) begin
                    n_fail++;
                    $display("FAIL basic_data c=%0d: got ts=%0d ld=%0d idx=%0d, want %0d %0d %0d",
                             c, ts, ld, idx, c-3, c-3+100, c-3);
                end
            end
            n_checks++;
            if (en !== (c >= 1 && c <= 4) || (en && addr !== AW'((c-1)*8))) begin
                n_fail++; $display("FAIL basic_bram c=%0d: got en=%b addr=%0d", c, en, addr);
            end
            n_checks++;
            if (done !== (c == 7) || busy !== (c >= 1 && c <= 7)) begin
                n_fail++; $display("FAIL basic_done_busy c=%0d: got done=%b busy=%b", c, done, busy);
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic test_zero;
        start = 1'b1; num = 15'd0; ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (en !== 1'b0 || valid !== 1'b0 || done !== (c == 2) || busy !== (c == 1 || c == 2)) begin
                n_fail++;
                $display("FAIL zero_pass c=%0d: got en=%b valid=%b done=%b busy=%b", c, en, valid, done, busy);
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic test_stall;
        int issued = 0, hs_cnt = 0, done_cnt = 0;
        logic prev_stall = 1'b0;
        logic [CW+LW+31:0] prev_word = '0;
        for (int c = 0; c < 40; c++) begin
            start = (c == 0) || (c == 5);  // second start lands mid-pass and must be ignored
            num   = (c == 5) ? 15'd1 : 15'd8;
            ready = (c % 2 == 0);
            @(negedge clk);
            if (en) issued++;
            if (done) done_cnt++;
            if (prev_stall) begin
                n_checks++;
                if (valid !== 1'b1 || {idx, ld, ts} !== prev_word) begin
                    n_fail++; $display("FAIL stall_hold c=%0d: got v=%b word=%0h want %0h", c, valid, {idx, ld, ts}, prev_word);
                end
            end
            if (valid && ready) begin
                n_checks++;
                if (idx !== CW'(hs_cnt) || ts !== 32'(hs_cnt) || ld !== 32'(hs_cnt+100)) begin
                    n_fail++; $display("FAIL stall_order c=%0d: got idx=%0d ts=%0d ld=%0d want %0d", c, idx, ts, ld, hs_cnt);
                end
                hs_cnt++;
            end
            n_checks++;
            if (issued - hs_cnt > 2) begin
                n_fail++; $display("FAIL stall_outstanding c=%0d: got %0d want <=2", c, issued - hs_cnt);
            end
            prev_stall = valid && !ready;
            prev_word  = {idx, ld, ts};
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_checks++;
        if (hs_cnt != 8 || done_cnt != 1) begin
            n_fail++; $display("FAIL stall_total: got hs=%0d done=%0d want 8 1", hs_cnt, done_cnt);
        end
    endtask

    task automatic test_full;
        int hs_cnt = 0, bad = 0, last_idx = -1, max_addr = 0;
        bit seen_done = 0;
        start = 1'b1; num = 15'(NE); ready = 1'b1;
        for (int c = 0; c < 16500 && !seen_done; c++) begin
            @(negedge clk);
            if (en && int'(addr) > max_addr) max_addr = int'(addr);
            if (valid) begin
                if (idx !== CW'(hs_cnt) || ts !== 32'(hs_cnt)) bad++;
                last_idx = int'(idx);
                hs_cnt++;
            end
            if (done) seen_done = 1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        n_checks++;
        if (last_idx != NE-1) begin n_fail++; $display("FAIL full_last_idx: got %0d want %0d", last_idx, NE-1); end
        n_checks++;
        if (max_addr != (NE-1)*8) begin n_fail++; $display("FAIL full_max_addr: got %0d want %0d", max_addr, (NE-1)*8); end
        n_checks++;
        if (hs_cnt != NE || bad != 0) begin n_fail++; $display("FAIL full_count: got hs=%0d bad=%0d want %0d 0", hs_cnt, bad, NE); end
        n_checks++;
        if (!seen_done) begin n_fail++; $display("FAIL full_done: got none want pulse"); end
    endtask

    task automatic test_abort;
        ready = 1'b1; num = 15'd10;
        for (int c = 0; c < 11; c++) begin
            start = (c == 0);
            abort = (c == 6);
            ready = (c != 6);
            @(negedge clk);
            if (c >= 3 && c <= 5) begin
                n_checks++;
                if (valid !== 1'b1 || idx !== CW'(c-3)) begin
                    n_fail++; $display("FAIL abort_pre c=%0d: got v=%b idx=%0d want 1 %0d", c, valid, idx, c-3);
                end
            end
            if (c >= 6) begin
                n_checks++;
                if (done !== 1'b0 || (c >= 7 && (valid !== 1'b0 || busy !== 1'b0))) begin
                    n_fail++; $display("FAIL abort_post c=%0d: got done=%b v=%b busy=%b", c, done, valid, busy);
                end
            end
            @(posedge clk); #1;
        end
        abort = 1'b0; ready = 1'b1; num = 15'd2;
        for (int c = 0; c < 7; c++) begin
            start = (c == 0);
            @(negedge clk);
            n_checks++;
            if (valid !== (c == 3 || c == 4) || (valid && (idx !== CW'(c-3) || ts !== 32'(c-3))) ||
                done !== (c == 5)) begin
                n_fail++; $display("FAIL abort_restart c=%0d: got v=%b idx=%0d ts=%0d done=%b", c, valid, idx, ts, done);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset;
        start = 1'b1; num = 15'd10; ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got v=%b busy=%b want 1 1", valid, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid, en, busy, done, addr, idx, ts, ld} !== '0) begin
            n_fail++; $display("FAIL areset_outputs: got v=%b en=%b busy=%b done=%b idx=%0d ts=%0d", valid, en, busy, done, idx, ts);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
                n_fail++; $display("FAIL areset_post c=%0d: got done=%b busy=%b v=%b", c, done, busy, valid);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_stall();
        test_full();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
